// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding and requester indices for the RAM port arbiter
package ram_arb_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;
endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner select; RAM_ARB_FIXED_PRIO_EN makes IDLE ties go to the CPU
module ram_arb_pick
    import ram_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic [1:0] i_state,
`ifndef RAM_ARB_FIXED_PRIO_EN
    input  logic       i_last,
`endif
    input  logic [7:0] i_hold_cnt,
    output logic       o_valid,
    output logic       o_win
);
    logic w_sat;
    logic w_tie;
    assign w_sat = (i_hold_cnt == 8'(MAX_HOLD));
`ifdef RAM_ARB_FIXED_PRIO_EN
    assign w_tie = REQ_CPU;
`else
    assign w_tie = ~i_last;
`endif
    // lock owner keeps the port unless the other side has waited out the hold limit
    always_comb begin
        o_valid = i_req0 | i_req1;
        o_win   = (i_state == ST_OWN0 && i_req0) ? (i_req1 && w_sat) :
                  (i_state == ST_OWN1 && i_req1) ? !(i_req0 && w_sat) :
                  (i_req0 && i_req1)             ? w_tie : i_req1;
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-requester arbiter for a 1-cycle-latency RAM; RAM_ARB_FIXED_PRIO_EN drops round robin
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_HOLD   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic                  i_lock0,
    input  logic                  i_lock1,
    input  logic [3:0]            i_we0,
    input  logic [3:0]            i_we1,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [31:0]           i_wdata0,
    input  logic [31:0]           i_wdata1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    output logic                  o_rvalid0,
    output logic                  o_rvalid1,
    output logic [31:0]           o_rdata,
    output logic [ADDR_WIDTH-1:0] o_ram_addra,
    output logic [31:0]           o_ram_dina,
    output logic [3:0]            o_ram_wea,
    output logic [ADDR_WIDTH-1:0] o_ram_addrb,
    input  logic [31:0]           i_ram_doutb
);
    logic                  w_valid, w_win, w_gnt, w_rd, w_lock, w_other;
    logic [3:0]            w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [1:0]            w_own_nx, w_state_nx;
    logic [7:0]            w_hold_nx;
    logic [1:0]            r_state;
    logic [7:0]            r_hold_cnt;
    logic [ADDR_WIDTH-1:0] r_addrb;
    logic                  r_rvalid0, r_rvalid1;
`ifndef RAM_ARB_FIXED_PRIO_EN
    logic                  r_last;
`endif

    ram_arb_pick #(.MAX_HOLD(MAX_HOLD)) u_pick (
        .i_req0     (i_req0),
        .i_req1     (i_req1),
        .i_state    (r_state),
`ifndef RAM_ARB_FIXED_PRIO_EN
        .i_last     (r_last),
`endif
        .i_hold_cnt (r_hold_cnt),
        .o_valid    (w_valid),
        .o_win      (w_win)
    );

    // route the winner onto the RAM ports; reset only blocks grants and writes
    always_comb begin
        w_gnt       = i_rst_n & w_valid;
        w_we        = w_win ? i_we1 : i_we0;
        w_addr      = w_win ? i_addr1 : i_addr0;
        w_lock      = w_win ? i_lock1 : i_lock0;
        w_other     = w_win ? i_req0 : i_req1;
        w_rd        = w_gnt && (w_we == 4'd0);
        o_gnt0      = w_gnt && !w_win;
        o_gnt1      = w_gnt && w_win;
        o_ram_wea   = w_gnt ? w_we : 4'd0;
        o_ram_addra = w_addr;
        o_ram_dina  = w_win ? i_wdata1 : i_wdata0;
        o_ram_addrb = w_valid ? w_addr : r_addrb;
    end

    // next lock owner and hold count; a new owner starts counting from its first grant
    always_comb begin
        w_own_nx   = w_win ? ST_OWN1 : ST_OWN0;
        w_state_nx = (w_valid && w_lock) ? w_own_nx : ST_IDLE;
        w_hold_nx  = (w_state_nx == ST_IDLE)        ? 8'd0 :
                     (w_own_nx != r_state)          ? 8'(w_other) :
                     (r_hold_cnt == 8'(MAX_HOLD))   ? r_hold_cnt : r_hold_cnt + 8'(w_other);
    end

    // arbitration state and read tags; reset drops any pending rvalid
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= 8'd0;
            r_addrb    <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_hold_cnt <= w_hold_nx;
            r_rvalid0  <= w_rd && !w_win;
            r_rvalid1  <= w_rd && w_win;
            if (w_valid) r_addrb <= w_addr;
        end
    end

`ifndef RAM_ARB_FIXED_PRIO_EN
    // remember the last winner so the other side takes the next tie
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_last <= 1'b1;
        else if (w_gnt) r_last <= w_win;
    end
`endif

    assign o_rvalid0 = r_rvalid0;
    assign o_rvalid1 = r_rvalid1;
    assign o_rdata   = i_ram_doutb;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random checks of ram_port_arbiter against a behavioural model
module tb_ram_port_arbiter;
    localparam int MH = 4;
    logic        clk, rst_n;
    logic        r0, r1, l0, l1;
    logic [3:0]  we0, we1;
    logic [13:0] a0, a1;
    logic [31:0] wd0, wd1;
    logic        gnt0, gnt1, rv0, rv1;
    logic [31:0] rdata, dina, doutb;
    logic [13:0] addra, addrb;
    logic [3:0]  wea;
    logic [31:0] mem [0:31];
    logic [31:0] mm  [0:31];
    int          n_chk, n_fail, m_owner, m_hold, m_last, g_w;
    bit          e_rv0, e_rv1;
    logic [31:0] e_data;
    logic [15:0] g_hist;

    ram_port_arbiter #(.ADDR_WIDTH(14), .MAX_HOLD(MH)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(r0), .i_req1(r1), .i_lock0(l0), .i_lock1(l1),
        .i_we0(we0), .i_we1(we1), .i_addr0(a0), .i_addr1(a1),
        .i_wdata0(wd0), .i_wdata1(wd1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rv0), .o_rvalid1(rv1),
        .o_rdata(rdata), .o_ram_addra(addra), .o_ram_dina(dina), .o_ram_wea(wea),
        .o_ram_addrb(addrb), .i_ram_doutb(doutb)
    );

    always #5 clk = ~clk;

    // simple synchronous RAM: byte-lane writes, 1-cycle registered read
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (wea[b]) mem[addra[4:0]][8*b +: 8] <= dina[8*b +: 8];
        doutb <= mem[addrb[4:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        m_owner = -1;
        m_hold  = 0;
        m_last  = 1;
        e_rv0   = 0;
        e_rv1   = 0;
    endtask

    // winner predicted from the arbitration rules; -1 when nobody requests
    function automatic int pick();
        if (m_owner == 0 && r0) return (r1 && m_hold >= MH) ? 1 : 0;
        if (m_owner == 1 && r1) return (r0 && m_hold >= MH) ? 0 : 1;
        if (r0 && r1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            return 0;
`else
            return (m_last == 0) ? 1 : 0;
`endif
        end
        return r0 ? 0 : (r1 ? 1 : -1);
    endfunction

    // one clock cycle: check outputs before the edge, advance the model after it
    task automatic tick();
        int          w, idx;
        logic [3:0]  we;
        logic [13:0] ad;
        logic [31:0] wd;
        bit          lk, oth;
        #1;
        if (!rst_n) mreset();
        w   = pick();
        we  = (w == 1) ? we1 : we0;
        ad  = (w == 1) ? a1 : a0;
        wd  = (w == 1) ? wd1 : wd0;
        lk  = (w == 1) ? l1 : l0;
        oth = (w == 1) ? r0 : r1;
        idx = int'(ad[4:0]);
        chk("gnt0", 32'(gnt0), 32'(rst_n && w == 0));
        chk("gnt1", 32'(gnt1), 32'(rst_n && w == 1));
        chk("rvalid0", 32'(rv0), 32'(e_rv0));
        chk("rvalid1", 32'(rv1), 32'(e_rv1));
        if (e_rv0 || e_rv1) chk("rdata", rdata, e_data);
        if (w >= 0 && rst_n) begin
            chk("wea", 32'(wea), 32'(we));
            if (we != 4'd0) begin
                chk("addra", 32'(addra), 32'(ad));
                chk("dina", dina, wd);
            end else chk("addrb", 32'(addrb), 32'(ad));
        end else chk("wea_idle", 32'(wea), 32'd0);
        g_hist = {g_hist[14:0], gnt1};
        @(posedge clk);
        e_rv0 = 0;
        e_rv1 = 0;
        if (!rst_n) mreset();
        else if (w >= 0) begin
            if (we == 4'd0) begin
                e_data = mm[idx];
                if (w == 0) e_rv0 = 1; else e_rv1 = 1;
            end
            for (int b = 0; b < 4; b++)
                if (we[b]) mm[idx][8*b +: 8] = wd[8*b +: 8];
            if (lk) begin
                m_hold  = (m_owner == w) ? ((m_hold + int'(oth) > MH) ? MH : m_hold + int'(oth)) : int'(oth);
                m_owner = w;
            end else begin
                m_owner = -1;
                m_hold  = 0;
            end
            m_last = w;
        end else begin
            m_owner = -1;
            m_hold  = 0;
        end
        g_w = rst_n ? w : -1;
        @(negedge clk);
    endtask

    task automatic set0(input logic r, input logic l, input logic [3:0] we, input int a, input logic [31:0] wd);
        r0 = r; l0 = l; we0 = we; a0 = 14'(a); wd0 = wd;
    endtask

    task automatic set1(input logic r, input logic l, input logic [3:0] we, input int a, input logic [31:0] wd);
        r1 = r; l1 = l; we1 = we; a1 = 14'(a); wd1 = wd;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    initial begin
        clk = 0; rst_n = 0; n_chk = 0; n_fail = 0; g_w = -1; g_hist = '0; e_data = '0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            mm[i]  = '0;
        end
        doutb = '0;
        mreset();
        set0(1, 0, 4'hF, 16, 32'hCAFE0000);
        set1(1, 0, 4'hF, 3, 32'h0BAD0BAD);
        @(negedge clk);
        tick();
        rst_n = 1;
        set1(0, 0, 4'h0, 0, 0);
        // write then read back the same word
        set0(1, 0, 4'hF, 16, 32'hDEADBEEF); tick();
        set0(1, 0, 4'h0, 16, 0);            tick();
        chk("raw_rvalid0", 32'(rv0), 32'd1);
        chk("raw_data", rdata, 32'hDEADBEEF);
        set0(0, 0, 4'h0, 0, 0);             tick();
        // byte-lane merge
        set0(1, 0, 4'hF, 5, 32'h11223344);  tick();
        set0(1, 0, 4'h2, 5, 32'h0000AA00);  tick();
        set0(1, 0, 4'h0, 5, 0);             tick();
        chk("lanes", rdata, 32'h1122AA44);
        set0(0, 0, 4'h0, 0, 0);             tick();
        // simultaneous reads from reset
        do_reset();
        set0(1, 0, 4'h0, 16, 0);
        set1(1, 0, 4'h0, 5, 0);
        repeat (4) tick();
        set0(0, 0, 4'h0, 0, 0);
        set1(0, 0, 4'h0, 0, 0);
        tick();
        // locked burst against a waiting requester
        do_reset();
        set0(1, 1, 4'h0, 16, 0);
        set1(1, 0, 4'h0, 5, 0);
        repeat (6) tick();
        chk("hold_pattern", 32'(g_hist[5:0]), 32'b000010);
        set0(0, 0, 4'h0, 0, 0);
        set1(0, 0, 4'h0, 0, 0);
        tick();
        // reset lands before the edge that would return read data
        set0(1, 0, 4'h0, 16, 0);
        #1 chk("pre_rst_gnt0", 32'(gnt0), 32'd1);
        #2 rst_n = 0;
        set0(0, 0, 4'h0, 0, 0);
        tick();
        tick();
        rst_n = 1;
        tick();
        // random traffic; a waiting requester holds its request until granted
        for (int i = 0; i < 600; i++) begin
            if (!r0 || g_w == 0)
                set0(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 1) ? 4'($urandom) : 4'h0, int'($urandom_range(0, 31)), $urandom);
            if (!r1 || g_w == 1)
                set1(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 1) ? 4'($urandom) : 4'h0, int'($urandom_range(0, 31)), $urandom);
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
